cordic_range_reducer: RTL and testbench

- Upstream pre-processing stage for `cordic_pipeline`. Each transaction carries a start vector (x, y) and a rotation angle z.
- The stage reduces an arbitrary signed Q6.10 angle into the CORDIC convergence range [-π/2, +π/2].
- Reduction subtracts or adds 2π iteratively, then folds by π, negating the vector on a fold.
- Its registered outputs drive `x0`/`y0`/`z0` of the pipeline directly. It accepts one transaction at a time under a valid/ready handshake.

---
 rtl/cordic_range_reducer_if.sv | 27 ++
 rtl/cordic_range_reducer.sv | 125 ++++++++++++
 tb/tb_cordic_range_reducer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_range_reducer_if.sv
// Valid/ready transaction bus: start vector and angle in, reduced vector and angle out.
// The reducer uses the slave side; the source and the CORDIC pipeline use the master side.
interface cordic_range_reducer_if #(
    parameter int W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic signed [W-1:0] z_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] x0;
    logic signed [W-1:0] y0;
    logic signed [W-1:0] z0;
    logic                out_flip;

    modport master (
        output in_valid, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, x0, y0, z0, out_flip
    );

    modport slave (
        input  in_valid, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, x0, y0, z0, out_flip
    );
endinterface

// File: rtl/cordic_range_reducer.sv
// Reduces a signed Q6.10 angle into [-pi/2, +pi/2] for the CORDIC pipeline:
// iterative 2*pi correction, then a single pi fold that negates the start vector.
module cordic_range_reducer #(
    parameter int W         = 16,
    parameter int C_PI      = 3217,
    parameter int C_HALF_PI = 1608,
    parameter int C_TWO_PI  = 6434
) (
    input  logic                  clk,
    input  logic                  rst,
    cordic_range_reducer_if.slave bus
);

    localparam logic signed [W-1:0] PI       = W'(C_PI);
    localparam logic signed [W-1:0] NEG_PI   = -PI;
    localparam logic signed [W-1:0] HALF     = W'(C_HALF_PI);
    localparam logic signed [W-1:0] NEG_HALF = -HALF;
    localparam logic signed [W-1:0] TWO_PI   = W'(C_TWO_PI);
    localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_FOLD,
        S_OUT
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_flip;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic signed [W-1:0] r_z;

    logic                w_fold_hi;
    logic                w_fold_lo;
    logic signed [W-1:0] w_z_folded;

    // The only unrepresentable negation is the most negative code; clamp it.
    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
        if (v == MOST_NEG) begin
            return MOST_POS;
        end
        return -v;
    endfunction

    always_comb begin
        w_fold_hi  = (r_z > HALF);
        w_fold_lo  = (r_z < NEG_HALF);
        w_z_folded = r_z;
        if (w_fold_hi) begin
            w_z_folded = r_z - PI;
        end else if (w_fold_lo) begin
            w_z_folded = r_z + PI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_flip      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_x        <= bus.x_in;
                        r_y        <= bus.y_in;
                        r_z        <= bus.z_in;
                        r_flip     <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_REDUCE;
                    end
                end
                // Each step moves z toward zero by 2*pi, so no overflow can occur.
                S_REDUCE: begin
                    if (r_z > PI) begin
                        r_z <= r_z - TWO_PI;
                    end else if (r_z < NEG_PI) begin
                        r_z <= r_z + TWO_PI;
                    end else begin
                        r_state <= S_FOLD;
                    end
                end
                S_FOLD: begin
                    if (w_fold_hi || w_fold_lo) begin
                        r_z    <= w_z_folded;
                        r_x    <= neg_sat(r_x);
                        r_y    <= neg_sat(r_y);
                        r_flip <= 1'b1;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                // Retiring always passes through IDLE, so no same-cycle accept.
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.x0        = r_x;
    assign bus.y0        = r_y;
    assign bus.z0        = r_z;
    assign bus.out_flip  = r_flip;

endmodule

// File: tb/tb_cordic_range_reducer.sv
// Self-checking bench for cordic_range_reducer: directed boundary cases, random
// transactions, backpressure, mid-transaction reset and back-to-back throughput.
module tb_cordic_range_reducer;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_range_reducer_if #(.W(W)) bus ();

    cordic_range_reducer #(
        .W(W), .C_PI(3217), .C_HALF_PI(1608), .C_TWO_PI(6434)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: plain-integer angle reduction following the arithmetic rules.
    function automatic int negsat(input int v);
        return (v == -32768) ? 32767 : -v;
    endfunction

    task automatic model(input int x, input int y, input int z,
                         output int ex, output int ey, output int ez,
                         output bit ef, output int n);
        n  = 0;
        ez = z;
        while (ez > 3217) begin ez = ez - 6434; n++; end
        while (ez < -3217) begin ez = ez + 6434; n++; end
        ex = x; ey = y; ef = 1'b0;
        if (ez > 1608 || ez < -1608) begin
            ez = (ez > 1608) ? ez - 3217 : ez + 3217;
            ex = negsat(x);
            ey = negsat(y);
            ef = 1'b1;
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Drives one transaction and measures it; comparisons stay with the callers.
    task automatic run_txn(input int x, input int y, input int z, input bit do_retire,
                           output int ox, output int oy, output int oz, output bit oflip,
                           output int lat, output bit ok);
        ok  = 1'b1;
        lat = 0;
        @(negedge clk);
        for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) @(negedge clk);
        bus.x_in     = x[W-1:0];
        bus.y_in     = y[W-1:0];
        bus.z_in     = z[W-1:0];
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (bus.out_valid !== 1'b1) ok = 1'b0;
        ox    = int'($signed(bus.x0));
        oy    = int'($signed(bus.y0));
        oz    = int'($signed(bus.z0));
        oflip = bus.out_flip;
        if (do_retire) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
        vectors++;
        if (bus.x0 !== '0 || bus.y0 !== '0 || bus.z0 !== '0 || bus.out_flip !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data: x0=%0d y0=%0d z0=%0d flip=%b, required all 0",
                     $signed(bus.x0), $signed(bus.y0), $signed(bus.z0), bus.out_flip);
        end
        rst = 1'b0;
    endtask

    typedef struct {
        int x; int y; int z;
        int ex; int ey; int ez; bit ef; int lat;
    } dvec_t;

    task automatic test_directed();
        dvec_t tbl[9];
        int ox, oy, oz, lat;
        bit of, ok;
        tbl[0] = '{1024, 0, 804, 1024, 0, 804, 1'b0, 3};
        tbl[1] = '{1024, 1024, 1608, 1024, 1024, 1608, 1'b0, 3};
        tbl[2] = '{1024, 0, 3217, -1024, 0, 0, 1'b1, 3};
        tbl[3] = '{1024, 512, 7000, 1024, 512, 566, 1'b0, 4};
        tbl[4] = '{1024, 0, -32768, 1024, 0, -598, 1'b0, 8};
        tbl[5] = '{-32768, 0, 2000, 32767, 0, -1217, 1'b1, 3};
        tbl[6] = '{300, -32768, -3217, -300, 32767, 0, 1'b1, 3};
        tbl[7] = '{-5, 7, -1608, -5, 7, -1608, 1'b0, 3};
        tbl[8] = '{100, 200, 3218, -100, -200, 1, 1'b1, 4};
        foreach (tbl[k]) begin
            run_txn(tbl[k].x, tbl[k].y, tbl[k].z, 1'b1, ox, oy, oz, of, lat, ok);
            vectors++;
            if (!ok || ox !== tbl[k].ex || oy !== tbl[k].ey || oz !== tbl[k].ez || of !== tbl[k].ef) begin
                miscompares++;
                $display("FAIL directed[%0d] data: got x=%0d y=%0d z=%0d flip=%b, required x=%0d y=%0d z=%0d flip=%b",
                         k, ox, oy, oz, of, tbl[k].ex, tbl[k].ey, tbl[k].ez, tbl[k].ef);
            end
            vectors++;
            if (lat !== tbl[k].lat) begin
                miscompares++;
                $display("FAIL directed[%0d] latency: got %0d, required %0d", k, lat, tbl[k].lat);
            end
            vectors++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL directed[%0d] retire: out_valid=%b in_ready=%b, required 0/1", k, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_random();
        int x, y, z, ex, ey, ez, n, ox, oy, oz, lat;
        bit ef, of, ok;
        for (int k = 0; k < 40; k++) begin
            x = ($urandom_range(0, 7) == 0) ? -32768 : rnd16();
            y = ($urandom_range(0, 7) == 0) ? -32768 : rnd16();
            z = rnd16();
            model(x, y, z, ex, ey, ez, ef, n);
            run_txn(x, y, z, 1'b1, ox, oy, oz, of, lat, ok);
            vectors++;
            if (!ok || ox !== ex || oy !== ey || oz !== ez || of !== ef || lat !== 3 + n) begin
                miscompares++;
                $display("FAIL random[%0d] z_in=%0d: got x=%0d y=%0d z=%0d flip=%b lat=%0d, required x=%0d y=%0d z=%0d flip=%b lat=%0d",
                         k, z, ox, oy, oz, of, lat, ex, ey, ez, ef, 3 + n);
            end
        end
    endtask

    task automatic test_backpressure();
        int ox, oy, oz, lat, ex, ey, ez, n, cnt;
        bit of, ok, ef;
        model(-700, 900, 5000, ex, ey, ez, ef, n);
        run_txn(-700, 900, 5000, 1'b0, ox, oy, oz, of, lat, ok);
        vectors++;
        if (!ok || ox !== ex || oy !== ey || oz !== ez || of !== ef) begin
            miscompares++;
            $display("FAIL bp_result: got x=%0d y=%0d z=%0d flip=%b, required x=%0d y=%0d z=%0d flip=%b",
                     ox, oy, oz, of, ex, ey, ez, ef);
        end
        // A second transaction waits on in_valid during the stall.
        bus.x_in = 16'sd11; bus.y_in = 16'sd22; bus.z_in = -16'sd2500;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || int'($signed(bus.x0)) !== ex ||
                int'($signed(bus.y0)) !== ey || int'($signed(bus.z0)) !== ez || bus.out_flip !== ef) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b x0=%0d z0=%0d, required 1/0 x0=%0d z0=%0d",
                         c, bus.out_valid, bus.in_ready, $signed(bus.x0), $signed(bus.z0), ex, ez);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_no_bypass: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        model(11, 22, -2500, ex, ey, ez, ef, n);
        cnt = 1;
        while (bus.out_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        vectors++;
        if (bus.out_valid !== 1'b1 || int'($signed(bus.x0)) !== ex || int'($signed(bus.y0)) !== ey ||
            int'($signed(bus.z0)) !== ez || bus.out_flip !== ef || cnt !== 3 + n) begin
            miscompares++;
            $display("FAIL bp_queued: out_valid=%b x0=%0d y0=%0d z0=%0d flip=%b lat=%0d, required x=%0d y=%0d z=%0d flip=%b lat=%0d",
                     bus.out_valid, $signed(bus.x0), $signed(bus.y0), $signed(bus.z0), bus.out_flip, cnt, ex, ey, ez, ef, 3 + n);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.x_in = 16'sd1234; bus.y_in = -16'sd77; bus.z_in = -16'sd32768;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.x0 !== '0 ||
            bus.y0 !== '0 || bus.z0 !== '0 || bus.out_flip !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b x0=%0d y0=%0d z0=%0d flip=%b, required 1/0 and zeros",
                     bus.in_ready, bus.out_valid, $signed(bus.x0), $signed(bus.y0), $signed(bus.z0), bus.out_flip);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_discard: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    typedef struct { int ex; int ey; int ez; bit ef; } exp_t;

    task automatic test_back_to_back();
        int zs[6] = '{100, 7000, -20000, 3217, 32767, -2000};
        int xs[6], ys[6], acc[6], nn[6];
        exp_t q[$];
        exp_t e;
        int idx, got, cyc, ex, ey, ez, n;
        bit ef, load_next;
        foreach (xs[k]) begin xs[k] = rnd16(); ys[k] = rnd16(); end
        idx = 0; got = 0; cyc = 0; load_next = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.x_in = xs[0][W-1:0]; bus.y_in = ys[0][W-1:0]; bus.z_in = zs[0][W-1:0];
        bus.in_valid = 1'b1;
        while (got < 6 && cyc < 300) begin
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_unexpected: out_valid with nothing outstanding at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    if (int'($signed(bus.x0)) !== e.ex || int'($signed(bus.y0)) !== e.ey ||
                        int'($signed(bus.z0)) !== e.ez || bus.out_flip !== e.ef) begin
                        miscompares++;
                        $display("FAIL b2b_data[%0d]: got x=%0d y=%0d z=%0d flip=%b, required x=%0d y=%0d z=%0d flip=%b",
                                 got, $signed(bus.x0), $signed(bus.y0), $signed(bus.z0), bus.out_flip, e.ex, e.ey, e.ez, e.ef);
                    end
                end
                got++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                model(xs[idx], ys[idx], zs[idx], ex, ey, ez, ef, n);
                q.push_back('{ex, ey, ez, ef});
                acc[idx] = cyc;
                nn[idx]  = n;
                idx++;
                load_next = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (load_next) begin
                load_next = 1'b0;
                if (idx < 6) begin
                    bus.x_in = xs[idx][W-1:0]; bus.y_in = ys[idx][W-1:0]; bus.z_in = zs[idx][W-1:0];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vectors++;
        if (got !== 6 || idx !== 6) begin
            miscompares++;
            $display("FAIL b2b_count: accepted %0d retired %0d, required 6/6", idx, got);
        end else begin
            for (int k = 0; k < 5; k++) begin
                vectors++;
                if (acc[k+1] - acc[k] !== 4 + nn[k]) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, required %0d", k, acc[k+1] - acc[k], 4 + nn[k]);
                end
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.z_in      = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
